seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit, common-anode 7-segment display on the Vaman board. It shares one active-low segment bus (a..g, dp) among four digit enables and inserts dead time between digits to suppress ghosting. It accepts new 4-digit BCD values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits. Upstream counters (decade and multi-digit counters) feed it instead of driving segment pins directly.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and BCD segment map for the 4-digit scan controller.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_e;

    // Non-decimal codes map to a dark digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        s = SEG_BLANK;
        case (bcd)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: nibble -> active-low segments and dp.
// Ports: nibble_i, lz_blank_i (force dark), dp_i (1 = lit) -> seg_o, dp_o.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       lz_blank_i,
    input  logic       dp_i,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    // A leading-zero blanked digit keeps its decimal point.
    assign seg_o = lz_blank_i ? SEG_BLANK : bcd_to_seg(nibble_i);
    assign dp_o  = ~dp_i;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller with dead time and frame-aligned
// loads. Ports: load_valid/load_ready/load_data/load_dp in, seg/dp/dig_en_n/frame_start out.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 20000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_en_n,
    output logic        frame_start
);

    localparam int           SW         = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    dig_q, dig_d;
    phase_e        phase_q, phase_d;

    logic [15:0]   disp_data_q, disp_data_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_valid_q, pend_valid_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    en_q, en_d;
    logic          fs_q, fs_d;

    logic          xfer;
    logic          boundary;
    logic [3:0]    nib;
    logic          lz;
    logic [6:0]    dec_seg;
    logic          dec_dp;

    assign xfer     = load_valid && !pend_valid_q;
    assign boundary = (slot_q == '0) && (dig_q == 2'd0);

    // Digit i is dark when it and every higher nibble are zero.
    always_comb begin
        nib = disp_data_q[{dig_q, 2'b00} +: 4];
        lz  = 1'b0;
        if (LZ_BLANK != 0 && dig_q != 2'd0) begin
            lz = (disp_data_q >> {dig_q, 2'b00}) == 16'h0;
        end
    end

    seg7_decode u_dec (
        .nibble_i   (nib),
        .lz_blank_i (lz),
        .dp_i       (disp_dp_q[dig_q]),
        .seg_o      (dec_seg),
        .dp_o       (dec_dp)
    );

    always_comb begin
        slot_d = slot_q + 1'b1;
        dig_d  = dig_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            dig_d  = dig_q + 2'd1;
        end
    end

    // Phase tracks the slot counter: BLANK for the first BLANK_CYCLES.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_BLANK: if (slot_q == BLANK_LAST) phase_d = PH_ON;
            PH_ON:    if (slot_q == SLOT_LAST)  phase_d = PH_BLANK;
        endcase
    end

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        en_d  = 4'hF;
        fs_d  = boundary;
        if (phase_q == PH_ON) begin
            seg_d = dec_seg;
            dp_d  = dec_dp;
            en_d  = ~(4'b0001 << dig_q);
        end
    end

    // Commit needs pend_valid, transfer needs !pend_valid: never both.
    always_comb begin
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (boundary && pend_valid_q) begin
            disp_data_d  = pend_data_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end
        if (xfer) begin
            pend_data_d  = load_data;
            pend_dp_d    = load_dp;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q       <= '0;
            dig_q        <= 2'd0;
            phase_q      <= PH_BLANK;
            disp_data_q  <= 16'hFFFF;
            disp_dp_q    <= 4'h0;
            pend_data_q  <= 16'h0;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            en_q         <= 4'hF;
            fs_q         <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            dig_q        <= dig_d;
            phase_q      <= phase_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            en_q         <= en_d;
            fs_q         <= fs_d;
        end
    end

    assign load_ready  = ~pend_valid_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dig_en_n    = en_q;
    assign frame_start = fs_q;

endmodule
